// File: rtl/vga_fb_fetch.sv
// Graphics-mode scanline fetch. A pipelined Wishbone read master copies one
// scanline at a time from the framebuffer into a small word FIFO. During
// active video the words are unpacked into 8bpp palette indices, one per clock.
//
// state | meaning
// IDLE  | no bus cycle; waiting for a line start (eos, or eol while lines remain)
// FETCH | cyc high; issuing reads for the current line and pushing ack data
// DRAIN | cyc high, stb low; discarding acks of an aborted line before restart
module vga_fb_fetch #(
   parameter int LINE_WORDS      = 160,
   parameter int LINES           = 480,
   parameter int FIFO_DEPTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] base,
   input  logic        eol,
   input  logic        eos,
   input  logic        h_active,
   input  logic        v_active,
   output logic [7:0]  pix,
   output logic        pix_valid,
   output logic        underrun,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic [31:0] bus_adr,
   output logic        bus_we,
   output logic [3:0]  bus_sel,
   input  logic [31:0] bus_dat,
   input  logic        bus_ack,
   input  logic        bus_stall
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(LINE_WORDS + 1);
   localparam int LW   = $clog2(LINES + 1);
   localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t          state;
   logic [31:0]     line_addr;
   logic [LW-1:0]   lines_left;
   logic            pending;
   logic [CW-1:0]   req_cnt;
   logic [CW-1:0]   ack_cnt;
   logic [OW-1:0]   outstanding;

   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic [1:0]      phase;

   logic [CNTW-1:0] free;
   logic [31:0]     head;
   logic            issue;
   logic            ack_live;
   logic            push;
   logic            pop;
   logic            active;
   logic            line_start;
   logic            sched;
   logic            line_done;
   logic            unused_base_bits;

   // Only bits [31:2] of base form the word-aligned line address.
   assign unused_base_bits = ^base[1:0];

   // Bus strobes and handshake terms, decoded from registered state only.
   // stb is withheld while a line start is pending so an abort never adds
   // new requests; the free-slot rule guarantees every ack has a FIFO slot.
   always_comb begin
      free       = CNTW'(FIFO_DEPTH) - count;
      bus_cyc    = (state != IDLE);
      bus_stb    = (state == FETCH) && !pending
                   && (req_cnt < CW'(LINE_WORDS))
                   && (outstanding < OW'(MAX_OUTSTANDING))
                   && (free > CNTW'(outstanding));
      bus_adr    = line_addr + (32'(req_cnt) << 2);
      bus_we     = 1'b0;
      bus_sel    = 4'hf;
      issue      = bus_stb && !bus_stall;
      ack_live   = bus_ack && (state != IDLE);
      push       = bus_ack && (state == FETCH);
      line_done  = push && (ack_cnt == CW'(LINE_WORDS - 1));
      line_start = pending && (outstanding == '0);
      active     = h_active && v_active;
      pop        = active && (count != '0) && (phase == 2'd3) && !line_start;
      sched      = eos || (eol && (lines_left != '0));
      head       = mem[rd_ptr];
   end

   // Fetch sequencer: line scheduling, request/ack accounting and FSM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         line_addr   <= '0;
         lines_left  <= '0;
         pending     <= 1'b0;
         req_cnt     <= '0;
         ack_cnt     <= '0;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + OW'(issue) - OW'(ack_live);
         if (issue)
            req_cnt <= req_cnt + CW'(1);
         if (push)
            ack_cnt <= ack_cnt + CW'(1);

         // A completed line advances the address even if a restart is pending,
         // so an eol arriving on the final ack still fetches the next line.
         if (line_done) begin
            line_addr <= line_addr + 32'(4 * LINE_WORDS);
            if (!pending)
               state <= IDLE;
         end

         if (pending) begin
            if (line_start) begin
               pending    <= 1'b0;
               req_cnt    <= '0;
               ack_cnt    <= '0;
               lines_left <= lines_left - LW'(1);
               state      <= FETCH;
            end else begin
               state <= DRAIN;
            end
         end

         if (sched)
            pending <= 1'b1;

         // eos takes precedence over both eol and a completing line.
         if (eos) begin
            line_addr  <= {base[31:2], 2'b00};
            lines_left <= LW'(LINES);
         end
      end
   end

   // FIFO storage; no reset needed since count gates every read.
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= bus_dat;
   end

   // FIFO pointers; a line start flushes whatever the previous line left.
   always_ff @(posedge clk_i) begin
      if (rst_i || line_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNTW'(push) - CNTW'(pop);
      end
   end

   // Pixel unpack: big-endian byte order within each word, one byte per
   // active clock; an empty FIFO yields index 0 and latches underrun.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pix       <= '0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
         phase     <= '0;
      end else begin
         pix_valid <= active;
         pix       <= '0;
         if (active) begin
            if (count == '0) begin
               underrun <= 1'b1;
            end else begin
               case (phase)
                  2'd0:    pix <= head[31:24];
                  2'd1:    pix <= head[23:16];
                  2'd2:    pix <= head[15:8];
                  default: pix <= head[7:0];
               endcase
               phase <= phase + 2'd1;
            end
         end
         if (line_start)
            phase <= '0;
         if (eos)
            underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Scoreboard bench for vga_fb_fetch: a pipelined Wishbone slave model with
// configurable latency/stall/hold, an address scoreboard on issued requests,
// and a pixel scoreboard on every pix_valid cycle.
module tb_vga_fb_fetch;

   localparam int LINE_WORDS = 160;
   localparam int LINES      = 480;
   localparam int BIG        = 1000000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] base = '0;
   logic        eol = 1'b0;
   logic        eos = 1'b0;
   logic        h_active = 1'b0;
   logic        v_active = 1'b0;
   logic [7:0]  pix;
   logic        pix_valid;
   logic        underrun;
   logic        bus_cyc;
   logic        bus_stb;
   logic [31:0] bus_adr;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_dat = '0;
   logic        bus_ack = 1'b0;
   logic        bus_stall = 1'b0;

   vga_fb_fetch dut (
      .clk_i(clk_i), .rst_i(rst_i), .base(base), .eol(eol), .eos(eos),
      .h_active(h_active), .v_active(v_active),
      .pix(pix), .pix_valid(pix_valid), .underrun(underrun),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_adr(bus_adr),
      .bus_we(bus_we), .bus_sel(bus_sel), .bus_dat(bus_dat),
      .bus_ack(bus_ack), .bus_stall(bus_stall)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %08h required %08h", name, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   typedef struct {
      logic [31:0] adr;
      int          due;
   } req_t;

   req_t        pend[$];
   logic [31:0] exp_adr[$];
   logic [7:0]  exp_pix[$];
   int          cyc_n = 0;
   int          lat = 1;
   bit          hold = 1'b0;
   bit          stall_alt = 1'b0;
   int          budget = BIG;
   int          issued = 0;
   int          inflight_max = 0;
   bit          chk_adr = 1'b0;
   bit          chk_pix = 1'b1;

   function automatic logic [31:0] dat_of(input logic [31:0] a);
      return 32'h0403_0201 + ((a - 32'h0010_0000) >> 2);
   endfunction

   always @(posedge clk_i) begin
      cyc_n++;
      if (bus_ack && pend.size() > 0)
         void'(pend.pop_front());
      if (bus_cyc && bus_stb && !bus_stall) begin
         pend.push_back('{bus_adr, cyc_n + lat});
         issued++;
         if (budget > 0)
            budget--;
         if (chk_adr) begin
            if (exp_adr.size() == 0)
               check("adr_extra", bus_adr, 32'hffff_ffff);
            else
               check("adr", bus_adr, exp_adr.pop_front());
         end
      end
      if (pend.size() > inflight_max)
         inflight_max = pend.size();
   end

   always @(negedge clk_i) begin
      bus_stall = (budget == 0) || (stall_alt && (cyc_n % 2 == 0));
      if (!hold && pend.size() > 0 && pend[0].due <= cyc_n + 1) begin
         bus_ack = 1'b1;
         bus_dat = dat_of(pend[0].adr);
      end else begin
         bus_ack = 1'b0;
         bus_dat = '0;
      end
   end

   // ---------------- pixel monitor ----------------
   always @(negedge clk_i) begin
      if (pix_valid && chk_pix) begin
         if (exp_pix.size() == 0)
            check("pix_extra", 32'(pix), 32'hffff_ffff);
         else
            check("pix", 32'(pix), 32'(exp_pix.pop_front()));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse(input bit do_eos, input bit do_eol);
      eos = do_eos;
      eol = do_eol;
      @(negedge clk_i);
      eos = 1'b0;
      eol = 1'b0;
   endtask

   task automatic run_active(input int n);
      h_active = 1'b1;
      v_active = 1'b1;
      repeat (n) @(negedge clk_i);
      h_active = 1'b0;
      v_active = 1'b0;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic push_line(input logic [31:0] first_word, input int words);
      logic [31:0] w;
      for (int n = 0; n < words; n++) begin
         w = first_word + 32'(n);
         exp_pix.push_back(w[31:24]);
         exp_pix.push_back(w[23:16]);
         exp_pix.push_back(w[15:8]);
         exp_pix.push_back(w[7:0]);
      end
   endtask

   task automatic wait_issued(input string name, input int target);
      int t = 0;
      while (issued < target && t < 50) begin
         @(negedge clk_i);
         t++;
      end
      check(name, 32'(issued >= target), 32'd1);
   endtask

   task automatic wait_pend_empty(input string name);
      int t = 0;
      while (pend.size() > 0 && t < 100) begin
         @(negedge clk_i);
         t++;
      end
      check(name, 32'(pend.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int issued0;
      bit saw_cyc;

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_cyc", 32'(bus_cyc), 32'd0);
      check("rst_stb", 32'(bus_stb), 32'd0);
      check("rst_adr", bus_adr, 32'd0);
      check("rst_pix", 32'(pix), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);

      // reset with three requests in flight
      hold = 1'b1;
      budget = 3;
      base = 32'h0010_0000;
      pulse(1'b1, 1'b0);
      wait_issued("t1_issue", 3);
      check("t1_outstanding", 32'(dut.outstanding), 32'd3);
      check("t1_cyc_before", 32'(bus_cyc), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check("t1_cyc", 32'(bus_cyc), 32'd0);
      check("t1_stb", 32'(bus_stb), 32'd0);
      check("t1_pix", 32'(pix), 32'd0);
      check("t1_fifo", 32'(dut.count), 32'd0);
      hold = 1'b0;
      wait_pend_empty("t1_acks_done");
      repeat (2) @(negedge clk_i);
      check("t1_fifo_after_acks", 32'(dut.count), 32'd0);
      check("t1_cyc_after_acks", 32'(bus_cyc), 32'd0);
      budget = BIG;

      // full line, zero-wait slave
      for (int n = 0; n < LINE_WORDS; n++)
         exp_adr.push_back(32'h0010_0000 + 32'(4 * n));
      chk_adr = 1'b1;
      pulse(1'b1, 1'b0);
      repeat (8) @(negedge clk_i);
      exp_pix.push_back(8'h04);
      exp_pix.push_back(8'h03);
      exp_pix.push_back(8'h02);
      exp_pix.push_back(8'h01);
      push_line(32'h0403_0202, LINE_WORDS - 1);
      run_active(4 * LINE_WORDS);
      check("t2_adr_left", 32'(exp_adr.size()), 32'd0);
      check("t2_pix_left", 32'(exp_pix.size()), 32'd0);
      check("t2_cyc_idle", 32'(bus_cyc), 32'd0);
      check("t2_line_addr", dut.line_addr, 32'h0010_0280);
      check("t2_underrun", 32'(underrun), 32'd0);

      // stall every other cycle, 5-cycle ack latency
      lat = 5;
      stall_alt = 1'b1;
      inflight_max = 0;
      for (int n = 0; n < LINE_WORDS; n++)
         exp_adr.push_back(32'h0010_0280 + 32'(4 * n));
      pulse(1'b0, 1'b1);
      repeat (40) @(negedge clk_i);
      push_line(32'h0403_0201 + 32'(LINE_WORDS), LINE_WORDS);
      run_active(4 * LINE_WORDS);
      check("t3_adr_left", 32'(exp_adr.size()), 32'd0);
      check("t3_pix_left", 32'(exp_pix.size()), 32'd0);
      check("t3_max_outstanding_ok", 32'(inflight_max <= 4), 32'd1);
      check("t3_underrun", 32'(underrun), 32'd0);
      check("t3_line_addr", dut.line_addr, 32'h0010_0500);
      stall_alt = 1'b0;
      chk_adr = 1'b0;

      // eos with two requests outstanding
      lat = 6;
      budget = 2;
      issued0 = issued;
      pulse(1'b0, 1'b1);
      wait_issued("t4_issue", issued0 + 2);
      check("t4_pend", 32'(pend.size()), 32'd2);
      base = 32'h0020_0000;
      for (int n = 0; n < LINE_WORDS; n++)
         exp_adr.push_back(32'h0020_0000 + 32'(4 * n));
      chk_adr = 1'b1;
      pulse(1'b1, 1'b0);
      lat = 1;
      @(negedge clk_i);
      check("t4_drain_state", 32'(dut.state), 32'd2);
      check("t4_drain_cyc", 32'(bus_cyc), 32'd1);
      check("t4_drain_stb", 32'(bus_stb), 32'd0);
      budget = BIG;
      repeat (15) @(negedge clk_i);
      exp_pix.push_back(8'h04);
      exp_pix.push_back(8'h07);
      exp_pix.push_back(8'h02);
      exp_pix.push_back(8'h01);
      exp_pix.push_back(8'h04);
      exp_pix.push_back(8'h07);
      exp_pix.push_back(8'h02);
      exp_pix.push_back(8'h02);
      run_active(8);
      check("t4_pix_left", 32'(exp_pix.size()), 32'd0);
      repeat (60) @(negedge clk_i);
      chk_adr = 1'b0;
      exp_adr.delete();

      // underrun with acks withheld
      wait_pend_empty("t5_quiet");
      hold = 1'b1;
      base = 32'h0010_0000;
      pulse(1'b1, 1'b0);
      repeat (6) @(negedge clk_i);
      for (int n = 0; n < 4; n++)
         exp_pix.push_back(8'h00);
      run_active(4);
      check("t5_pix_left", 32'(exp_pix.size()), 32'd0);
      check("t5_underrun", 32'(underrun), 32'd1);
      repeat (10) @(negedge clk_i);
      check("t5_underrun_sticky", 32'(underrun), 32'd1);
      pulse(1'b1, 1'b0);
      check("t5_underrun_clear", 32'(underrun), 32'd0);
      hold = 1'b0;
      wait_pend_empty("t5_release");
      repeat (60) @(negedge clk_i);

      // eol and eos together
      base = 32'h0030_0000;
      for (int n = 0; n < LINE_WORDS; n++)
         exp_adr.push_back(32'h0030_0000 + 32'(4 * n));
      chk_adr = 1'b1;
      pulse(1'b1, 1'b1);
      repeat (12) @(negedge clk_i);
      check("t6_lines_left", 32'(dut.lines_left), 32'(LINES - 1));
      check("t6_line_addr", dut.line_addr, 32'h0030_0000);
      check("t6_fetched", 32'(exp_adr.size() < LINE_WORDS), 32'd1);
      repeat (40) @(negedge clk_i);
      chk_adr = 1'b0;
      exp_adr.delete();

      // run out the frame, then one eol too many
      for (int i = 0; i < LINES - 1; i++) begin
         pulse(1'b0, 1'b1);
         repeat (11) @(negedge clk_i);
      end
      check("t7_lines_left", 32'(dut.lines_left), 32'd0);
      chk_pix = 1'b0;
      h_active = 1'b1;
      v_active = 1'b1;
      t = 0;
      while (bus_cyc && t < 3000) begin
         @(negedge clk_i);
         t++;
      end
      h_active = 1'b0;
      v_active = 1'b0;
      repeat (3) @(negedge clk_i);
      check("t7_line_done", 32'(bus_cyc), 32'd0);
      issued0 = issued;
      saw_cyc = 1'b0;
      pulse(1'b0, 1'b1);
      repeat (30) begin
         if (bus_cyc)
            saw_cyc = 1'b1;
         @(negedge clk_i);
      end
      check("t7_no_cycle", 32'(saw_cyc), 32'd0);
      check("t7_no_issue", 32'(issued - issued0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
